uart_sram_burst_bridge: RTL and testbench

- Next-generation UART/SRAM exerciser for the board's shared data bus: a burst engine with parameterised width, depth and transform.
- On a start pulse it receives N bytes from the external UART chip and writes them to SRAM at base, base+1, ... It then reads them back and transmits each one plus INC through the UART.
- The UART chip and SRAM share one bidirectional bus; this block arbitrates the bus strictly by state.

---
 rtl/uart_sram_burst_bridge.sv | 192 +++++++++++++++++++
 tb/tb_uart_sram_burst_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sram_burst_bridge.sv
// Burst exerciser for a shared UART/SRAM bus: receives N bytes over the UART, stores them
// at base..base+N-1, then reads each one back and transmits it plus INC.
module uart_sram_burst_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18,
  parameter int LEN_W  = 4,
  parameter int INC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre,
  inout  logic [DATA_W-1:0] bus_io,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en_n,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic              rdn,
  output logic              wrn,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] last_word,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RX_WAIT  = 4'd1,
    RX_RD    = 4'd2,
    WR_SET   = 4'd3,
    WR_PULSE = 4'd4,
    WR_HOLD  = 4'd5,
    RD_SET   = 4'd6,
    RD_CAP   = 4'd7,
    TX_DRIVE = 4'd8,
    TX_HOLD  = 4'd9,
    TX_WAIT  = 4'd10,
    FIN      = 4'd11
  } state_e;

  function automatic logic [DATA_W-1:0] add_inc(input logic [DATA_W-1:0] w);
    return w + DATA_W'(INC);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wbuf_q;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rdn_q, rdn_d;
  logic                wrn_q, wrn_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                en_n_q, en_n_d;
  logic                drv_q, drv_d;
  logic                txsel_q, txsel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                idx_last;

  assign idx_last = (idx_q == LEN_W'(len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = burst_len;
          idx_d   = '0;
          state_d = (burst_len == '0) ? FIN : RX_WAIT;
        end
      end
      RX_WAIT:  if (data_ready) state_d = RX_RD;
      RX_RD:    state_d = WR_SET;
      WR_SET:   state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD: begin
        if (idx_last) begin
          idx_d   = '0;
          state_d = RD_SET;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = RX_WAIT;
        end
      end
      RD_SET:   state_d = RD_CAP;
      RD_CAP:   state_d = TX_DRIVE;
      TX_DRIVE: state_d = TX_HOLD;
      TX_HOLD:  state_d = TX_WAIT;
      TX_WAIT: begin
        if (tbre && tsre) begin
          if (idx_last) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = RD_SET;
          end
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // tracks the current state exactly and cannot glitch.
  always_comb begin
    rdn_d   = (state_d != RX_RD);
    wrn_d   = (state_d != TX_DRIVE);
    we_n_d  = (state_d != WR_PULSE);
    oe_n_d  = !(state_d inside {RD_SET, RD_CAP});
    en_n_d  = !(state_d inside {[WR_SET:TX_WAIT]});
    drv_d   = state_d inside {WR_SET, WR_PULSE, WR_HOLD, TX_DRIVE, TX_HOLD};
    txsel_d = state_d inside {TX_DRIVE, TX_HOLD};
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
    addr_d  = addr_q;
    if (state_d inside {WR_SET, RD_SET}) addr_d = base_d + ADDR_W'(idx_d);
    last_d  = last_q;
    // wbuf is loaded on this same edge, so take the word straight off the bus.
    if (state_d == TX_DRIVE) last_d = add_inc(bus_io);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      en_n_q  <= 1'b1;
      drv_q   <= 1'b0;
      txsel_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      last_q  <= '0;
    end else begin
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      en_n_q  <= en_n_d;
      drv_q   <= drv_d;
      txsel_q <= txsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == RX_RD || state_q == RD_CAP) wbuf_q <= bus_io;
  end

  assign bus_io    = drv_q ? (txsel_q ? add_inc(wbuf_q) : wbuf_q) : 'z;
  assign ram_addr  = addr_q;
  assign ram_en_n  = en_n_q;
  assign ram_we_n  = we_n_q;
  assign ram_oe_n  = oe_n_q;
  assign rdn       = rdn_q;
  assign wrn       = wrn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign last_word = last_q;
  assign state     = state_q;

endmodule

// File: tb/tb_uart_sram_burst_bridge.sv
// Bench for uart_sram_burst_bridge: UART and SRAM models on the shared bus, a burst-level
// reference model, and a per-cycle strobe/contention monitor.
module tb_uart_sram_burst_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] base_addr;
  logic [3:0]  burst_len;
  logic        data_ready, tbre, tsre;
  wire  [7:0]  bus_io;
  logic [17:0] ram_addr;
  logic        ram_en_n, ram_we_n, ram_oe_n, rdn, wrn, busy, done;
  logic [7:0]  last_word;
  logic [3:0]  state;

  uart_sram_burst_bridge dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .bus_io(bus_io),
    .ram_addr(ram_addr), .ram_en_n(ram_en_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
    .rdn(rdn), .wrn(wrn), .busy(busy), .done(done), .last_word(last_word), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // External device models
  logic [7:0]  mem [0:262143];
  logic [7:0]  rx_arr [0:15];
  int          rd_seen = 0;
  int          rd_base = 0;
  logic [3:0]  rx_idx;
  assign rx_idx = 4'(rd_seen - rd_base);
  assign bus_io = !rdn ? rx_arr[rx_idx] :
                  (!ram_en_n && !ram_oe_n) ? mem[ram_addr] : 'z;

  always @(posedge clk) if (rst && !rdn) rd_seen <= rd_seen + 1;

  logic [17:0] wl_addr [$];
  logic [7:0]  wl_data [$];
  logic [7:0]  tx_log  [$];
  int          done_cnt   = 0;
  int          contention = 0;
  int          strobe_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      if ((state inside {4'd3, 4'd4, 4'd5, 4'd8, 4'd9}) && (!ram_oe_n || !rdn))
        contention <= contention + 1;
      if (rdn != (state != 4'd2) || wrn != (state != 4'd8) || ram_we_n != (state != 4'd4) ||
          ram_oe_n != !(state == 4'd6 || state == 4'd7) ||
          ram_en_n != !(state >= 4'd3 && state <= 4'd10) ||
          busy != (state != 4'd0) || done != (state == 4'd11))
        strobe_err <= strobe_err + 1;
      if (!ram_en_n && !ram_we_n) begin
        wl_addr.push_back(ram_addr);
        wl_data.push_back(bus_io);
        mem[ram_addr] <= bus_io;
      end
      if (!wrn) tx_log.push_back(bus_io);
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  logic [7:0] exp_last = 8'h00;

  task automatic drive_random();
    data_ready = ($urandom_range(0, 3) != 0);
    tbre       = ($urandom_range(0, 3) != 0);
    tsre       = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_burst(input logic [17:0] b, input int n,
                           input bit stall_rx, input bit stall_tx, input bit inj_start);
    int wl0, tx0, d0, err, t0;
    bit fin, srx, stx, sinj;
    wl0 = wl_addr.size(); tx0 = tx_log.size(); d0 = done_cnt;
    fin = 0; srx = 0; stx = 0; sinj = 0;
    rd_base = rd_seen;
    @(negedge clk);
    base_addr = b; burst_len = 4'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (done_cnt != d0 && state == 4'd0) begin
        fin = 1;
      end else begin
        start = 1'b0;
        if (stall_rx && !srx && state == 4'd1) begin
          srx = 1; err = 0; data_ready = 1'b0;
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (state != 4'd1 || !rdn) err++;
          end
          chk("rx_stall", err, 0);
        end else if (stall_tx && !stx && state == 4'd10) begin
          stx = 1; err = 0; t0 = tx_log.size(); tbre = 1'b1; tsre = 1'b0;
          for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (state != 4'd10) err++;
          end
          chk("tx_stall_state", err, 0);
          chk("tx_stall_wrn", tx_log.size() - t0, 0);
        end else begin
          if (inj_start && !sinj && state == 4'd1) begin
            sinj = 1; start = 1'b1; base_addr = ~b; burst_len = 4'(n + 3);
          end
          drive_random();
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) chk("burst_timeout", 0, 1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("wr_count", wl_addr.size() - wl0, n);
    chk("tx_count", tx_log.size() - tx0, n);
    for (int i = 0; i < n && wl0 + i < wl_addr.size(); i++) begin
      chk("wr_addr", wl_addr[wl0 + i], (int'(b) + i) % 262144);
      chk("wr_data", wl_data[wl0 + i], rx_arr[i]);
    end
    for (int i = 0; i < n && tx0 + i < tx_log.size(); i++)
      chk("tx_data", tx_log[tx0 + i], (int'(rx_arr[i]) + 1) % 256);
    if (n > 0) exp_last = 8'((int'(rx_arr[n-1]) + 1) % 256);
    chk("last_word", last_word, exp_last);
  endtask

  initial begin
    int d0, wl0, tx0, r0;
    bit hit;
    rst = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_last_word", last_word, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_strobes", {rdn, wrn, ram_we_n, ram_oe_n, ram_en_n}, 5'h1F);
    chk("rst_busy_done", {busy, done}, 2'b00);
    rst = 1'b1;
    @(negedge clk);

    rx_arr[0] = 8'h41;
    run_burst(18'h00010, 1, 0, 0, 0);
    chk("b1_last_word", last_word, 8'h42);

    rx_arr[0] = 8'h10; rx_arr[1] = 8'h20; rx_arr[2] = 8'h30;
    run_burst(18'h00100, 3, 1, 0, 0);

    rx_arr[0] = 8'hFF; rx_arr[1] = 8'h05;
    run_burst(18'h3FFFF, 2, 0, 1, 0);

    // Zero-length burst
    d0 = done_cnt; wl0 = wl_addr.size(); tx0 = tx_log.size(); r0 = rd_seen;
    @(negedge clk);
    base_addr = 18'h00005; burst_len = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    chk("len0_state", state, 11);
    chk("len0_done", done, 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("len0_idle", {state, done}, 5'h00);
    @(negedge clk);
    chk("len0_done_cnt", done_cnt - d0, 1);
    chk("len0_activity", (wl_addr.size() - wl0) + (tx_log.size() - tx0) + (rd_seen - r0), 0);
    chk("len0_last_word", last_word, exp_last);

    for (int i = 0; i < 4; i++) rx_arr[i] = 8'($urandom);
    run_burst(18'h01234, 4, 0, 0, 1);

    // Reset asserted during the write pulse
    for (int i = 0; i < 3; i++) rx_arr[i] = 8'($urandom);
    rd_base = rd_seen;
    @(negedge clk);
    base_addr = 18'h00200; burst_len = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_ready = 1'b1; hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (state == 4'd4) hit = 1;
      else @(negedge clk);
    end
    chk("reach_wr_pulse", hit, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_we_n", ram_we_n, 1);
    chk("rstmid_en_n", ram_en_n, 1);
    chk("rstmid_state", state, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_after", state, 0);
    exp_last = 8'h00;

    for (int t = 0; t < 8; t++) begin
      logic [17:0] b;
      int n;
      n = $urandom_range(1, 15);
      b = ($urandom_range(0, 3) == 0) ? 18'(18'h3FFFF - $urandom_range(0, 7)) : 18'($urandom);
      for (int i = 0; i < n; i++)
        rx_arr[i] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      run_burst(b, n, 0, 0, 0);
    end

    chk("contention", contention, 0);
    chk("strobe_vs_state", strobe_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
